// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter for the serial system bus.
// Grants one master at a time and latches its target slave select as a
// one-hot slave enable. The grant is held until tx_done, the owner drops its
// request, or TIMEOUT cycles pass. Then one RELEASE turnaround cycle follows.
// Optional macro ROUND_ROBIN_EN: when defined, IDLE ties go to the master that
// was not the last owner. When undefined, master 1 always wins ties.
module bus_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int SLAVES  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m1_req,
  input  logic              m2_req,
  input  logic [1:0]        m1_slave_sel,
  input  logic [1:0]        m2_slave_sel,
  input  logic              tx_done,
  output logic              m1_grant,
  output logic              m2_grant,
  output logic [SLAVES-1:0] slave_en,
  output logic              bus_busy,
  output logic              timeout_err,
  output logic              sel_err
);

  localparam int             CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LIMIT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic           OWNER_M1  = 1'b0;
  localparam logic           OWNER_M2  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic                last_owner_r, last_owner_s;
  logic                m1_grant_r, m1_grant_s;
  logic                m2_grant_r, m2_grant_s;
  logic [SLAVES-1:0]   slave_en_r, slave_en_s;
  logic                bus_busy_r, bus_busy_s;
  logic                timeout_err_r, timeout_err_s;
  logic                sel_err_r, sel_err_s;

  logic                m1_ok_s, m2_ok_s;
  logic                pick_m1_s, pick_m2_s;
  logic                tie_to_m2_s;
  logic                owner_req_s;
  logic [1:0]          win_sel_s;

  // A select is usable only when it addresses an existing slave.
  function automatic logic sel_valid(input logic [1:0] sel);
    return (int'(sel) < SLAVES);
  endfunction

  // One-hot decode of a slave index.
  function automatic logic [SLAVES-1:0] sel_onehot(input logic [1:0] sel);
    logic [SLAVES-1:0] oh;
    oh = '0;
    for (int i = 0; i < SLAVES; i++) begin
      oh[i] = (int'(sel) == i);
    end
    return oh;
  endfunction

`ifdef ROUND_ROBIN_EN
  // On a tie, prefer master 2 when master 1 owned the bus last.
  assign tie_to_m2_s = (last_owner_r == OWNER_M1);
`else
  // Fixed priority: master 1 always wins a tie; last owner is only tracked.
  logic unused_last_owner_s;
  assign unused_last_owner_s = last_owner_r;
  assign tie_to_m2_s = 1'b0;
`endif

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    last_owner_s  = last_owner_r;
    m1_grant_s    = m1_grant_r;
    m2_grant_s    = m2_grant_r;
    slave_en_s    = slave_en_r;
    timeout_err_s = 1'b0;
    sel_err_s     = 1'b0;
    m1_ok_s       = m1_req && sel_valid(m1_slave_sel);
    m2_ok_s       = m2_req && sel_valid(m2_slave_sel);
    pick_m2_s     = m2_ok_s && (!m1_ok_s || tie_to_m2_s);
    pick_m1_s     = m1_ok_s && !pick_m2_s;
    win_sel_s     = pick_m2_s ? m2_slave_sel : m1_slave_sel;
    owner_req_s   = m1_grant_r ? m1_req : m2_req;

    case (state_r)
      ST_IDLE: begin
        sel_err_s = (m1_req && !m1_ok_s) || (m2_req && !m2_ok_s);
        if (pick_m1_s || pick_m2_s) begin
          state_s    = ST_GRANT;
          m1_grant_s = pick_m1_s;
          m2_grant_s = pick_m2_s;
          slave_en_s = sel_onehot(win_sel_s);
          cnt_s      = '0;
        end else begin
          m1_grant_s = 1'b0;
          m2_grant_s = 1'b0;
          slave_en_s = '0;
        end
      end
      ST_GRANT: begin
        if (tx_done || !owner_req_s || (cnt_r == CNT_LIMIT)) begin
          state_s       = ST_RELEASE;
          m1_grant_s    = 1'b0;
          m2_grant_s    = 1'b0;
          slave_en_s    = '0;
          cnt_s         = '0;
          last_owner_s  = m2_grant_r ? OWNER_M2 : OWNER_M1;
          // Only reachable reason left once tx_done and abort are excluded.
          timeout_err_s = !tx_done && owner_req_s;
        end else begin
          cnt_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
        end
      end
      ST_RELEASE: begin
        state_s    = ST_IDLE;
        m1_grant_s = 1'b0;
        m2_grant_s = 1'b0;
        slave_en_s = '0;
      end
      default: begin
        state_s    = ST_IDLE;
        cnt_s      = '0;
        m1_grant_s = 1'b0;
        m2_grant_s = 1'b0;
        slave_en_s = '0;
      end
    endcase

    bus_busy_s = (state_s != ST_IDLE);
  end

  // State, counter and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      last_owner_r  <= OWNER_M2;
      m1_grant_r    <= 1'b0;
      m2_grant_r    <= 1'b0;
      slave_en_r    <= '0;
      bus_busy_r    <= 1'b0;
      timeout_err_r <= 1'b0;
      sel_err_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      last_owner_r  <= last_owner_s;
      m1_grant_r    <= m1_grant_s;
      m2_grant_r    <= m2_grant_s;
      slave_en_r    <= slave_en_s;
      bus_busy_r    <= bus_busy_s;
      timeout_err_r <= timeout_err_s;
      sel_err_r     <= sel_err_s;
    end
  end

  assign m1_grant    = m1_grant_r;
  assign m2_grant    = m2_grant_r;
  assign slave_en    = slave_en_r;
  assign bus_busy    = bus_busy_r;
  assign timeout_err = timeout_err_r;
  assign sel_err     = sel_err_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a transaction-level reference model
// predicts the outputs after every clock edge; a monitor compares them.
module tb_bus_arbiter;

  localparam int TIMEOUT = 64;
  localparam int SLAVES  = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              m1_req = 1'b0, m2_req = 1'b0, tx_done = 1'b0;
  logic [1:0]        m1_slave_sel = 2'd0, m2_slave_sel = 2'd0;
  logic              m1_grant, m2_grant, bus_busy, timeout_err, sel_err;
  logic [SLAVES-1:0] slave_en;

  bus_arbiter #(.TIMEOUT(TIMEOUT), .SLAVES(SLAVES)) dut (
    .clk(clk), .reset(reset),
    .m1_req(m1_req), .m2_req(m2_req),
    .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
    .tx_done(tx_done),
    .m1_grant(m1_grant), .m2_grant(m2_grant), .slave_en(slave_en),
    .bus_busy(bus_busy), .timeout_err(timeout_err), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              m1g;
    logic              m2g;
    logic [SLAVES-1:0] en;
    logic              busy;
    logic              terr;
    logic              serr;
  } obs_t;

  obs_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model: who owns the bus, for how many cycles, and history.
  int owner   = 0;   // 0 = nobody, 1 = master 1, 2 = master 2
  bit in_rel  = 1'b0;
  int age     = 0;   // cycles since the grant edge
  int last    = 2;
  int lat_sel = 0;

  task automatic model_step(output obs_t e);
    int w;
    bit v1, v2, req;
    e = '0;
    if (reset) begin
      owner = 0; in_rel = 1'b0; age = 0; last = 2;
    end else if (in_rel) begin
      in_rel = 1'b0;
    end else if (owner != 0) begin
      req = (owner == 1) ? m1_req : m2_req;
      if (tx_done || !req || (age + 1 == TIMEOUT)) begin
        e.terr = !tx_done && req;
        e.busy = 1'b1;
        last   = owner;
        owner  = 0;
        in_rel = 1'b1;
      end else begin
        age++;
        e.m1g  = (owner == 1);
        e.m2g  = (owner == 2);
        e.en   = SLAVES'(1 << lat_sel);
        e.busy = 1'b1;
      end
    end else begin
      v1 = m1_req && (int'(m1_slave_sel) < SLAVES);
      v2 = m2_req && (int'(m2_slave_sel) < SLAVES);
      e.serr = (m1_req && !v1) || (m2_req && !v2);
      w = 0;
      if (v1 && v2) begin
`ifdef ROUND_ROBIN_EN
        w = (last == 1) ? 2 : 1;
`else
        w = 1;
`endif
      end else if (v1) begin
        w = 1;
      end else if (v2) begin
        w = 2;
      end
      if (w != 0) begin
        owner   = w;
        age     = 0;
        lat_sel = (w == 1) ? int'(m1_slave_sel) : int'(m2_slave_sel);
        e.m1g   = (w == 1);
        e.m2g   = (w == 2);
        e.en    = SLAVES'(1 << lat_sel);
        e.busy  = 1'b1;
      end
    end
  endtask

  // Apply one cycle of inputs and queue the outputs expected after the edge.
  task automatic drive(input bit rst, input bit r1, input bit r2,
                       input logic [1:0] s1, input logic [1:0] s2, input bit td);
    obs_t e;
    @(negedge clk);
    #1;
    reset = rst; m1_req = r1; m2_req = r2;
    m1_slave_sel = s1; m2_slave_sel = s2; tx_done = td;
    model_step(e);
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation.
  initial begin
    obs_t got, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {m1_grant, m2_grant, slave_en, bus_busy, timeout_err, sel_err};
        compared++;
        if (got !== e) begin
          mismatched++;
          $display("FAIL outputs @%0t: got m1g=%b m2g=%b en=%b busy=%b terr=%b serr=%b, expected m1g=%b m2g=%b en=%b busy=%b terr=%b serr=%b",
                   $time, got.m1g, got.m2g, got.en, got.busy, got.terr, got.serr,
                   e.m1g, e.m2g, e.en, e.busy, e.terr, e.serr);
        end
      end
    end
  end

  initial begin
    // Reset for two cycles.
    repeat (2) drive(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);

    // Single request, tx_done around grant+20.
    drive(1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
    repeat (19) drive(1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0);

    // Contention, tx_done after 15 grant cycles.
    for (int i = 0; i < 60; i++)
      drive(1'b0, 1'b1, 1'b1, 2'd0, 2'd2, (owner != 0) && (age == 14));
    repeat (2) drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);

    // Timeout with master 2 alone, then re-grant.
    repeat (140) drive(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);

    // Invalid select on master 1.
    repeat (6) drive(1'b0, 1'b1, 1'b1, 2'd3, 2'd2, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 2'd3, 2'd2, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);

    // Abort at grant+5.
    repeat (6) drive(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);

    // tx_done coinciding with the timeout limit.
    for (int i = 0; i < 70; i++)
      drive(1'b0, 1'b1, 1'b0, 2'd1, 2'd0, (owner == 1) && (age == TIMEOUT - 1));
    repeat (2) drive(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);

    // Reset mid-grant, then a tie.
    repeat (7) drive(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 1'b0);
    repeat (4) drive(1'b0, 1'b1, 1'b1, 2'd0, 2'd1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++)
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);

    @(negedge clk);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
